// File: rtl/traffic_phase_sched.sv
// Two-road intersection phase sequencer: main road owns the junction by default; side road is
// granted on a 3-of-5 sensor majority or a latched pedestrian request; emergency pre-empts to main.
module traffic_phase_sched #(
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 8,
  parameter int MAX_SIDE  = 6,
  parameter int MIN_SIDE  = 2,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sensor,
  input  logic       ped_req,
  input  logic       emergency,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       ped_walk,
  output logic [2:0] phase,
  output logic       phase_start
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5
  } state_e;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  localparam logic [CNT_W-1:0] T_MIN_GREEN = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_MAX_SIDE  = CNT_W'(MAX_SIDE - 1);
  localparam logic [CNT_W-1:0] T_MIN_SIDE  = CNT_W'(MIN_SIDE - 1);
  localparam logic [CNT_W-1:0] T_YELLOW    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] T_ALLRED    = CNT_W'(ALLRED_T - 1);

  // State kept as raw bits so the unused codes 6/7 stay representable and recoverable.
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             ped_pend_q, ped_pend_d;
  logic [2:0]       main_q, main_d;
  logic [2:0]       side_q, side_d;
  logic             walk_q, walk_d;
  logic             start_q, start_d;

  logic [2:0] pop;
  logic       vote;
  logic       side_req;
  logic       chg;

  always_comb begin
    pop = 3'd0;
    for (int i = 0; i < 5; i++) pop = pop + 3'(sensor[i]);
  end

  assign vote     = (pop >= 3'd3);
  assign side_req = vote | ped_pend_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_GREEN:
        if (tmr_q >= T_MIN_GREEN && side_req && !emergency) state_d = MAIN_YELLOW;
      MAIN_YELLOW:
        if (tmr_q == T_YELLOW) state_d = ALL_RED_A;
      ALL_RED_A:
        if (tmr_q == T_ALLRED) state_d = emergency ? MAIN_GREEN : SIDE_GREEN;
      SIDE_GREEN:
        if (emergency || tmr_q == T_MAX_SIDE || (tmr_q >= T_MIN_SIDE && !vote))
          state_d = SIDE_YELLOW;
      SIDE_YELLOW:
        if (tmr_q == T_YELLOW) state_d = ALL_RED_B;
      ALL_RED_B:
        if (tmr_q == T_ALLRED) state_d = MAIN_GREEN;
      default:
        state_d = MAIN_GREEN;
    endcase
  end

  assign chg = (state_d != state_q);

  always_comb begin
    tmr_d = tmr_q;
    if (chg)         tmr_d = '0;
    else if (~&tmr_q) tmr_d = tmr_q + 1'b1;
  end

  // Entering side green consumes the request, even one arriving on that same clock.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (state_d == SIDE_GREEN && state_q != SIDE_GREEN) ped_pend_d = 1'b0;
    else if (ped_req && state_q != SIDE_GREEN)          ped_pend_d = 1'b1;
  end

  // Lights decode from next state so the registered outputs switch on the state edge.
  always_comb begin
    main_d  = L_GRN;
    side_d  = L_RED;
    walk_d  = 1'b0;
    start_d = chg;
    case (state_d)
      MAIN_YELLOW: begin main_d = L_YEL; side_d = L_RED; end
      ALL_RED_A,
      ALL_RED_B:   begin main_d = L_RED; side_d = L_RED; end
      SIDE_GREEN:  begin main_d = L_RED; side_d = L_GRN; walk_d = 1'b1; end
      SIDE_YELLOW: begin main_d = L_RED; side_d = L_YEL; end
      default:     begin main_d = L_GRN; side_d = L_RED; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MAIN_GREEN;
      tmr_q      <= '0;
      ped_pend_q <= 1'b0;
      main_q     <= L_GRN;
      side_q     <= L_RED;
      walk_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      ped_pend_q <= ped_pend_d;
      main_q     <= main_d;
      side_q     <= side_d;
      walk_q     <= walk_d;
      start_q    <= start_d;
    end
  end

  assign main_lights = main_q;
  assign side_lights = side_q;
  assign ped_walk    = walk_q;
  assign phase       = state_q;
  assign phase_start = start_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for traffic_phase_sched: phase timelines, pre-emption, ped corners, reset, recovery.
module tb_traffic_phase_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] sensor;
  logic       ped_req;
  logic       emergency;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       ped_walk;
  logic [2:0] phase;
  logic       phase_start;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  traffic_phase_sched dut (
    .clk         (clk),
    .rst         (rst),
    .sensor      (sensor),
    .ped_req     (ped_req),
    .emergency   (emergency),
    .main_lights (main_lights),
    .side_lights (side_lights),
    .ped_walk    (ped_walk),
    .phase       (phase),
    .phase_start (phase_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock; afterwards we sit inside cycle cyc and may drive inputs for its end.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; sensor = '0; ped_req = 1'b0; emergency = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 1;
  endtask

  // Hand-written light table per phase code.
  function automatic logic [5:0] lights_of(input int p);
    case (p)
      0: return 6'b001_100;
      1: return 6'b010_100;
      2: return 6'b100_100;
      3: return 6'b100_001;
      4: return 6'b100_010;
      5: return 6'b100_100;
      default: return 6'b001_100;
    endcase
  endfunction

  // Timeline for held majority demand: MG 1-8, MY 9-11, ARA 12-13, SG 14-19, SY 20-22, ARB 23-24.
  function automatic int maj_phase(input int c);
    if (c <= 8)  return 0;
    if (c <= 11) return 1;
    if (c <= 13) return 2;
    if (c <= 19) return 3;
    if (c <= 22) return 4;
    if (c <= 24) return 5;
    return 0;
  endfunction

  int seq3[14] = '{0, 1, 1, 1, 2, 2, 3, 3, 4, 4, 4, 5, 5, 0};

  initial begin
    // 1. Reset state then idle
    do_reset();
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_main", 32'(main_lights), 32'b001);
    chk("rst_side", 32'(side_lights), 32'b100);
    chk("rst_walk", 32'(ped_walk), 32'd0);
    chk("rst_start", 32'(phase_start), 32'd0);
    chk("rst_tmr", 32'(dut.tmr_q), 32'd0);
    chk("rst_pend", 32'(dut.ped_pend_q), 32'd0);
    for (int i = 0; i < 100; i++) begin
      step();
      chk("idle_main", 32'(main_lights), 32'b001);
      chk("idle_side", 32'(side_lights), 32'b100);
      chk("idle_start", 32'(phase_start), 32'd0);
    end

    // 2. Held majority 10101
    do_reset();
    sensor = 5'b10101;
    for (int c = 1; c <= 27; c++) begin
      if (c > 1) step();
      chk("maj_phase", 32'(phase), 32'(maj_phase(c)));
      chk("maj_lights", 32'({main_lights, side_lights}), 32'(lights_of(maj_phase(c))));
      chk("maj_walk", 32'(ped_walk), 32'(maj_phase(c) == 3));
      chk("maj_start", 32'(phase_start),
          32'(c == 9 || c == 12 || c == 14 || c == 20 || c == 23 || c == 25));
    end

    // 3. Sub-majority never switches; one ped pulse gives one short side phase
    do_reset();
    sensor = 5'b00011;
    repeat (30) step();
    chk("sub_hold", 32'(phase), 32'd0);
    chk("sub_tmr", 32'(dut.tmr_q), 32'd30);
    ped_req = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      ped_req = 1'b0;
      if (i == 0) chk("sub_pend_set", 32'(dut.ped_pend_q), 32'd1);
      chk("sub_phase", 32'(phase), 32'(seq3[i]));
      chk("sub_walk", 32'(ped_walk), 32'(seq3[i] == 3));
    end
    chk("sub_pend_clr", 32'(dut.ped_pend_q), 32'd0);
    repeat (20) step();
    chk("sub_stay", 32'(phase), 32'd0);

    // 4a. Emergency in SIDE_GREEN cycle 1, held through MAIN_GREEN
    do_reset();
    sensor = 5'b11111;
    repeat (13) step();
    chk("emg_sg1", 32'(phase), 32'd3);
    emergency = 1'b1;
    step(); chk("emg_sy", 32'(phase), 32'd4);
    step(); step();
    step(); chk("emg_arb", 32'(phase), 32'd5);
    step(); step(); chk("emg_mg", 32'(phase), 32'd0);
    repeat (20) step();
    chk("emg_hold", 32'(phase), 32'd0);
    chk("emg_hold_lt", 32'({main_lights, side_lights}), 32'b001_100);
    emergency = 1'b0;
    step(); chk("emg_release", 32'(phase), 32'd1);

    // 4b. Emergency in ALL_RED_A returns to main, pending ped kept
    do_reset();
    ped_req = 1'b1;
    step(); ped_req = 1'b0;
    chk("ara_pend", 32'(dut.ped_pend_q), 32'd1);
    repeat (10) step();
    chk("ara_in", 32'(phase), 32'd2);
    emergency = 1'b1;
    step(); chk("ara_last", 32'(phase), 32'd2);
    step();
    chk("ara_mg", 32'(phase), 32'd0);
    chk("ara_start", 32'(phase_start), 32'd1);
    chk("ara_keep", 32'(dut.ped_pend_q), 32'd1);
    emergency = 1'b0;

    // 5. Ped on the SIDE_GREEN entry clock and during SIDE_GREEN
    do_reset();
    sensor = 5'b10101;
    repeat (12) step();
    chk("ped_ara2", 32'(phase), 32'd2);
    ped_req = 1'b1;
    step(); ped_req = 1'b0;
    chk("ped_sg", 32'(phase), 32'd3);
    chk("ped_entry_clr", 32'(dut.ped_pend_q), 32'd0);
    ped_req = 1'b1;
    step(); ped_req = 1'b0;
    chk("ped_ign", 32'(dut.ped_pend_q), 32'd0);
    repeat (4) step();
    sensor = 5'b00000;
    repeat (20) step();
    chk("ped_no_extra", 32'(phase), 32'd0);

    // 6. Reset in SIDE_YELLOW, then illegal-state recovery
    do_reset();
    sensor = 5'b10101;
    repeat (20) step();
    chk("mid_sy", 32'(phase), 32'd4);
    rst = 1'b1;
    step(); rst = 1'b0; sensor = 5'b00000;
    chk("mid_phase", 32'(phase), 32'd0);
    chk("mid_lights", 32'({main_lights, side_lights}), 32'b001_100);
    chk("mid_tmr", 32'(dut.tmr_q), 32'd0);
    chk("mid_start", 32'(phase_start), 32'd0);
    step();
    force dut.state_q = 3'd7;
    #1;
    chk("ill_forced", 32'(phase), 32'd7);
    release dut.state_q;
    step();
    chk("ill_recover", 32'(phase), 32'd0);
    chk("ill_lights", 32'({main_lights, side_lights}), 32'b001_100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
